// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between a master and the memory responder.
// Clock and reset stay outside as plain ports.
interface ahb_lite_mem_slave_if;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hmastlock;
  logic        hwrite;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport slave (
    input  haddr, hburst, hprot, hsize, htrans, hwdata, hmastlock, hwrite,
    output hready, hresp, hrdata
  );

  modport master (
    output haddr, hburst, hprot, hsize, htrans, hwdata, hmastlock, hwrite,
    input  hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word memory responder with programmable wait states, two-cycle ERROR
// response and a sticky end-of-simulation flag written through DONE_ADDR.
module ahb_lite_mem_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] DONE_ADDR   = 32'h4000_0000,
  parameter logic [31:0] DONE_DATA   = 32'h0000_000d
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  ahb_lite_mem_slave_if.slave  bus,
  output logic                 done_o
);

  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam logic [32:0] MemBytes = 33'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic              write_q;
  logic              done_sel_q;
  logic              done_q;
  logic [31:0]       mem [MEM_WORDS];

  logic              hready;
  logic              hresp;
  logic [31:0]       hrdata;
  logic [32:0]       off_in;
  logic              in_range;
  logic              is_done_in;
  logic              addr_err;
  logic              accept;
  logic              commit;

  // Address-phase decode; the whole classification is decided at the sampling edge.
  assign off_in     = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
  assign in_range   = !off_in[32] && (off_in < MemBytes);
  assign is_done_in = (bus.haddr == DONE_ADDR);
  assign addr_err   = (bus.hsize != 3'h2) || (bus.haddr[1:0] != 2'b00) ||
                      (!in_range && !is_done_in);
  assign accept     = hready && bus.htrans[1];
  assign commit     = (state_q == StData) && write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    unique case (state_q)
      StWait: begin
        hready = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = StErr2;
      end
      StErr2:  hresp = 1'b1;
      default: ;
    endcase
    // Whenever ready, the current edge also samples the next address phase.
    if (hready) begin
      if (bus.htrans[1]) begin
        if (addr_err) begin
          state_d = StErr1;
        end else if (WAIT_STATES != 0) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_STATES - 1);
        end else begin
          state_d = StData;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      done_sel_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q      <= off_in[IdxW+1:2];
        write_q    <= bus.hwrite;
        done_sel_q <= is_done_in;
      end
      if (commit && done_sel_q && (bus.hwdata == DONE_DATA)) begin
        done_q <= 1'b1;
      end
    end
  end

  // Memory contents survive reset; state_q is held in StIdle while reset is low.
  always_ff @(posedge hclk) begin
    if (commit && !done_sel_q) begin
      mem[idx_q] <= bus.hwdata;
    end
  end

  always_comb begin
    hrdata = '0;
    if ((state_q == StData) && !write_q) begin
      hrdata = done_sel_q ? {31'b0, done_q} : mem[idx_q];
    end
  end

  assign bus.hready = hready;
  assign bus.hresp  = hresp;
  assign bus.hrdata = hrdata;
  assign done_o     = done_q;

  logic unused_inputs;
  assign unused_inputs = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: a zero-wait and a two-wait instance share one
// pipelined master; a negedge monitor pops expected beats from a scoreboard queue.
module tb_ahb_lite_mem_slave;

  localparam logic [1:0] Idle   = 2'b00;
  localparam logic [1:0] Busy   = 2'b01;
  localparam logic [1:0] Nonseq = 2'b10;
  localparam logic [1:0] Seq    = 2'b11;
  localparam logic [31:0] DoneA = 32'h4000_0000;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        resp;
    logic        chk;
    logic [31:0] rdata;
    int          waits;
  } beat_t;

  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] haddr = '0;
  logic [2:0]  hsize = 3'h2;
  logic [1:0]  htrans = Idle;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic        done0, done2;
  logic        hready, hresp;
  logic [31:0] hrdata;

  int n_cmp = 0;
  int n_err = 0;
  beat_t cmd_q[$];
  beat_t exp_q[$];
  bit    pending = 1'b0;
  int    waits = 0;

  ahb_lite_mem_slave_if bus0 ();
  ahb_lite_mem_slave_if bus2 ();

  assign bus0.haddr = haddr;   assign bus2.haddr = haddr;
  assign bus0.hsize = hsize;   assign bus2.hsize = hsize;
  assign bus0.hwdata = hwdata; assign bus2.hwdata = hwdata;
  assign bus0.hwrite = hwrite; assign bus2.hwrite = hwrite;
  assign bus0.hburst = 3'b000; assign bus2.hburst = 3'b000;
  assign bus0.hprot = 4'h3;    assign bus2.hprot = 4'h3;
  assign bus0.hmastlock = 1'b0; assign bus2.hmastlock = 1'b0;
  assign bus0.htrans = sel ? Idle : htrans;
  assign bus2.htrans = sel ? htrans : Idle;

  assign hready = sel ? bus2.hready : bus0.hready;
  assign hresp  = sel ? bus2.hresp  : bus0.hresp;
  assign hrdata = sel ? bus2.hrdata : bus0.hrdata;

  ahb_lite_mem_slave #(.WAIT_STATES(0)) dut0 (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus0),
    .done_o   (done0)
  );

  ahb_lite_mem_slave #(.WAIT_STATES(2)) dut2 (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus2),
    .done_o   (done2)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic [2:0] size, input logic [1:0] trans, input logic resp,
                     input logic chk, input logic [31:0] rdata, input int wt);
    beat_t b;
    b.addr = addr; b.wr = wr; b.wdata = wdata; b.size = size; b.trans = trans;
    b.resp = resp; b.chk = chk; b.rdata = rdata; b.waits = wt;
    cmd_q.push_back(b);
  endtask

  // Pipelined master: the next address goes out with the previous beat's write data.
  task automatic drive_all();
    beat_t b;
    logic  rdy;
    while (cmd_q.size() != 0) begin
      b = cmd_q.pop_front();
      haddr = b.addr; hwrite = b.wr; hsize = b.size; htrans = b.trans;
      if (b.trans[1]) exp_q.push_back(b);
      rdy = 1'b0;
      for (int i = 0; i < 20 && !rdy; i++) begin
        @(negedge hclk);
        rdy = hready;
        @(posedge hclk);
        #1;
      end
      check_eq($sformatf("accept@%h", b.addr), rdy, 1'b1);
      hwdata = b.wdata;
    end
    htrans = Idle;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge hclk);
    #1;
    check_eq("scoreboard_drained", exp_q.size(), 0);
  endtask

  always @(negedge hclk) begin
    beat_t e;
    if (!hreset_n) begin
      pending = 1'b0;
      waits   = 0;
    end else begin
      if (pending) begin
        check_eq("scoreboard_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          if (!hready) begin
            check_eq($sformatf("hresp_stall@%h", exp_q[0].addr), hresp, exp_q[0].resp);
            waits++;
          end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("hresp@%h", e.addr), hresp, e.resp);
            if (e.chk) check_eq($sformatf("hrdata@%h", e.addr), hrdata, e.rdata);
            check_eq($sformatf("wait_cycles@%h", e.addr), waits, e.waits);
            pending = 1'b0;
            waits   = 0;
          end
        end
      end
      if (hready && htrans[1]) pending = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    #12;
    check_eq("rst_hready0", bus0.hready, 1'b1);
    check_eq("rst_hresp0", bus0.hresp, 1'b0);
    check_eq("rst_hrdata0", bus0.hrdata, 32'h0);
    check_eq("rst_done0", done0, 1'b0);
    check_eq("rst_hready2", bus2.hready, 1'b1);
    check_eq("rst_done2", done2, 1'b0);
    @(negedge hclk);
    hreset_n = 1'b1;
    repeat (2) @(posedge hclk);
    #1;

    // Zero-wait instance: write/read, bursts, errors, done register.
    sel = 1'b0;
    add(32'h10, 1'b1, 32'hDEADBEEF, 3'h2, Nonseq, 1'b0, 1'b0, 32'h0, 0);
    add(32'h10, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++)
      add(32'h100 + 32'(4 * i), 1'b1, 32'(i + 1), 3'h2, (i == 0) ? Nonseq : Seq,
          1'b0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 4; i++)
      add(32'h100 + 32'(4 * i), 1'b0, 32'h0, 3'h2, (i == 0) ? Nonseq : Seq,
          1'b0, 1'b1, 32'(i + 1), 0);
    drive_all();

    add(32'h0000_1002, 1'b0, 32'h0, 3'h2, Nonseq, 1'b1, 1'b0, 32'h0, 1);
    add(32'h0001_0000, 1'b0, 32'h0, 3'h2, Nonseq, 1'b1, 1'b0, 32'h0, 1);
    add(32'h10, 1'b1, 32'h1111_2222, 3'h1, Nonseq, 1'b1, 1'b0, 32'h0, 1);
    add(32'h0001_0000, 1'b1, 32'h3333_4444, 3'h2, Nonseq, 1'b1, 1'b0, 32'h0, 1);
    add(32'h104, 1'b0, 32'h0, 3'h2, Busy, 1'b0, 1'b0, 32'h0, 0);
    add(32'h10, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'hDEADBEEF, 0);
    add(32'h10C, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'h4, 0);
    drive_all();

    add(DoneA, 1'b1, 32'h0c, 3'h2, Nonseq, 1'b0, 1'b0, 32'h0, 0);
    drive_all();
    check_eq("done_after_0c", done0, 1'b0);
    add(DoneA, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'h0, 0);
    add(DoneA, 1'b1, 32'h0d, 3'h2, Nonseq, 1'b0, 1'b0, 32'h0, 0);
    drive_all();
    check_eq("done_after_0d", done0, 1'b1);
    repeat (5) @(posedge hclk);
    #1;
    check_eq("done_sticky", done0, 1'b1);
    add(DoneA, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'h1, 0);
    drive_all();

    // Two-wait instance.
    sel = 1'b1;
    add(32'h20, 1'b1, 32'hCAFEF00D, 3'h2, Nonseq, 1'b0, 1'b0, 32'h0, 2);
    add(32'h40, 1'b1, 32'h0000_005A, 3'h2, Nonseq, 1'b0, 1'b0, 32'h0, 2);
    add(32'h20, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'hCAFEF00D, 2);
    drive_all();

    // Reset during the wait state of a write must abort it.
    add(32'h40, 1'b1, 32'h77, 3'h2, Nonseq, 1'b0, 1'b0, 32'h0, 2);
    begin
      beat_t b;
      b = cmd_q.pop_front();
      haddr = b.addr; hwrite = b.wr; hsize = b.size; htrans = b.trans;
      exp_q.push_back(b);
      @(negedge hclk);
      @(posedge hclk);
      #1;
      hwdata = b.wdata;
      htrans = Idle;
    end
    @(negedge hclk);
    check_eq("in_wait_hready", bus2.hready, 1'b0);
    #1;
    hreset_n = 1'b0;
    #1;
    check_eq("async_rst_hready", bus2.hready, 1'b1);
    check_eq("async_rst_hresp", bus2.hresp, 1'b0);
    check_eq("async_rst_hrdata", bus2.hrdata, 32'h0);
    check_eq("async_rst_done0", done0, 1'b0);
    repeat (2) @(posedge hclk);
    exp_q.delete();
    @(negedge hclk);
    hreset_n = 1'b1;
    @(posedge hclk);
    #1;
    add(32'h40, 1'b0, 32'h0, 3'h2, Nonseq, 1'b0, 1'b1, 32'h0000_005A, 2);
    drive_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
